// File: rtl/bc_reg_pkg.sv
// Shared definitions for the basic-computer register family: operation select
// encodings and the standard datapath widths.
package bc_reg_pkg;

  localparam int unsigned BC_WORD_W = 16;
  localparam int unsigned BC_ADDR_W = 12;

  localparam int unsigned OP_W = 3;
  typedef logic [OP_W-1:0] op_sel_t;

  localparam op_sel_t OP_HOLD = 3'd0;
  localparam op_sel_t OP_CLR  = 3'd1;
  localparam op_sel_t OP_LD   = 3'd2;
  localparam op_sel_t OP_INR  = 3'd3;
  localparam op_sel_t OP_SHL  = 3'd4;
  localparam op_sel_t OP_SHR  = 3'd5;

  // True when an increment from the current value rolls over to zero.
  function automatic logic will_wrap(input op_sel_t op, input logic all_ones);
    return (op == OP_INR) && all_ones;
  endfunction

endpackage

// File: rtl/bc_reg_bit.sv
// One bit slice of the multifunction register: synchronous-reset flop with a
// complement output taken from the same storage bit.
module bc_reg_bit (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= rst_val;
    end else begin
      q <= d;
    end
  end

  // Derived from q itself so the complement can never lag the true output.
  assign qbar = ~q;

endmodule

// File: rtl/bc_multifunc_register.sv
// WIDTH-bit clear/load/increment register with registered wrap flag.
// Optional serial shift left/right when BC_REG_SHIFT_EN is defined.
module bc_multifunc_register
  import bc_reg_pkg::*;
#(
  parameter int unsigned WIDTH       = BC_WORD_W,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_clr,
  input  logic             reg_ld,
  input  logic             reg_inr,
  input  logic [WIDTH-1:0] reg_in,
`ifdef BC_REG_SHIFT_EN
  input  logic             reg_shl,
  input  logic             reg_shr,
  input  logic             reg_sin,
  output logic             reg_sout,
`endif
  output logic [WIDTH-1:0] reg_out,
  output logic [WIDTH-1:0] reg_out_bar,
  output logic             reg_zero,
  output logic             reg_wrap
);

  localparam logic [WIDTH-1:0] RstVal = RESET_VALUE[WIDTH-1:0];

  op_sel_t          op_sel;
  logic [WIDTH-1:0] reg_nxt;
  logic             wrap_d;
  logic             wrap_q;

  // Reset is applied inside the storage flops, so it is not part of this encoder.
  always_comb begin
    op_sel = OP_HOLD;
    if (reg_clr) begin
      op_sel = OP_CLR;
    end else if (reg_ld) begin
      op_sel = OP_LD;
    end else if (reg_inr) begin
      op_sel = OP_INR;
`ifdef BC_REG_SHIFT_EN
    end else if (reg_shl) begin
      op_sel = OP_SHL;
    end else if (reg_shr) begin
      op_sel = OP_SHR;
`endif
    end
  end

  always_comb begin
    reg_nxt = reg_out;
    case (op_sel)
      OP_CLR:  reg_nxt = '0;
      OP_LD:   reg_nxt = reg_in;
      OP_INR:  reg_nxt = WIDTH'(reg_out + 1'b1);
`ifdef BC_REG_SHIFT_EN
      OP_SHL:  reg_nxt = {reg_out[WIDTH-2:0], reg_sin};
      OP_SHR:  reg_nxt = {reg_sin, reg_out[WIDTH-1:1]};
`endif
      default: reg_nxt = reg_out;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bc_reg_bit u_bit (
      .clk     (clk),
      .reset   (reset),
      .rst_val (RstVal[i]),
      .d       (reg_nxt[i]),
      .q       (reg_out[i]),
      .qbar    (reg_out_bar[i])
    );
  end

  assign wrap_d = will_wrap(op_sel, &reg_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign reg_wrap = wrap_q;
  assign reg_zero = (reg_out == '0);

`ifdef BC_REG_SHIFT_EN
  logic sout_q;

  // Serial output keeps the bit shifted out until the next shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      sout_q <= 1'b0;
    end else if (op_sel == OP_SHL) begin
      sout_q <= reg_out[WIDTH-1];
    end else if (op_sel == OP_SHR) begin
      sout_q <= reg_out[0];
    end
  end

  assign reg_sout = sout_q;
`endif

endmodule

// File: tb/tb_bc_multifunc_register.sv
// Self-checking bench: behavioural model + per-cycle compare, directed literal
// checks, then randomized control traffic.
module tb_bc_multifunc_register;

  localparam int unsigned W    = 16;
  localparam int unsigned RV   = 32'h0005;
  localparam int unsigned MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         reg_clr = 1'b0;
  logic         reg_ld = 1'b0;
  logic         reg_inr = 1'b0;
  logic [W-1:0] reg_in = '0;
  logic [W-1:0] reg_out;
  logic [W-1:0] reg_out_bar;
  logic         reg_zero;
  logic         reg_wrap;
`ifdef BC_REG_SHIFT_EN
  logic         reg_shl = 1'b0;
  logic         reg_shr = 1'b0;
  logic         reg_sin = 1'b0;
  logic         reg_sout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bc_multifunc_register #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .reg_clr     (reg_clr),
    .reg_ld      (reg_ld),
    .reg_inr     (reg_inr),
    .reg_in      (reg_in),
`ifdef BC_REG_SHIFT_EN
    .reg_shl     (reg_shl),
    .reg_shr     (reg_shr),
    .reg_sin     (reg_sin),
    .reg_sout    (reg_sout),
`endif
    .reg_out     (reg_out),
    .reg_out_bar (reg_out_bar),
    .reg_zero    (reg_zero),
    .reg_wrap    (reg_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer arithmetic over the priority rules.
  int unsigned m_val   = 0;
  bit          m_wrap  = 0;
  bit          m_sout  = 0;
  bit          m_valid = 0;

  always @(posedge clk) begin : model
    int unsigned v;
    bit w;
    bit s;
    v = m_val;
    w = 0;
    s = m_sout;
    if (reset) begin
      v = RV & MASK;
      s = 0;
    end else if (reg_clr) begin
      v = 0;
    end else if (reg_ld) begin
      v = reg_in;
    end else if (reg_inr) begin
      w = (v == MASK);
      v = (v + 1) % (MASK + 1);
`ifdef BC_REG_SHIFT_EN
    end else if (reg_shl) begin
      s = (v >> (W - 1)) & 1;
      v = ((v << 1) | reg_sin) & MASK;
    end else if (reg_shr) begin
      s = v & 1;
      v = (v >> 1) | (int'(reg_sin) << (W - 1));
`endif
    end
    if (reset) m_valid <= 1'b1;
    m_val  <= v;
    m_wrap <= w;
    m_sout <= s;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("out", reg_out, m_val);
      check("out_bar", reg_out_bar, ~m_val & MASK);
      check("zero", reg_zero, (m_val == 0));
      check("wrap", reg_wrap, m_wrap);
`ifdef BC_REG_SHIFT_EN
      check("sout", reg_sout, m_sout);
`endif
    end
  end

  // Drive one cycle of controls (called at a negedge) and return at the next negedge.
  task automatic apply(input bit r, input bit c, input bit l, input bit i,
                       input logic [W-1:0] d);
    reset   = r;
    reg_clr = c;
    reg_ld  = l;
    reg_inr = i;
    reg_in  = d;
    @(negedge clk);
  endtask

  initial begin
    apply(1, 0, 0, 0, 16'h0000);
    check("rst_out", reg_out, 16'h0005);
    check("rst_bar", reg_out_bar, 16'hFFFA);
    check("rst_wrap", reg_wrap, 1'b0);
    check("rst_zero", reg_zero, 1'b0);

    apply(0, 0, 1, 0, 16'hFFFE);
    check("ld_fffe", reg_out, 16'hFFFE);
    apply(0, 0, 0, 1, 16'h0000);
    check("inr_ffff", reg_out, 16'hFFFF);
    check("inr_ffff_wrap", reg_wrap, 1'b0);
    apply(0, 0, 0, 1, 16'h0000);
    check("wrap_out", reg_out, 16'h0000);
    check("wrap_flag", reg_wrap, 1'b1);
    check("wrap_zero", reg_zero, 1'b1);
    apply(0, 0, 0, 0, 16'h0000);
    check("hold_after_wrap", reg_wrap, 1'b0);

    apply(0, 0, 1, 1, 16'h1234);
    check("ld_inr_out", reg_out, 16'h1234);
    check("ld_inr_wrap", reg_wrap, 1'b0);
    apply(0, 0, 0, 0, 16'h5555);
    check("hold_1234", reg_out, 16'h1234);

    apply(0, 1, 1, 0, 16'hABCD);
    check("clr_ld", reg_out, 16'h0000);

    apply(0, 0, 1, 0, 16'h0010);
    apply(1, 0, 0, 1, 16'h0000);
    check("rst_mid_inr", reg_out, 16'h0005);
    apply(0, 0, 0, 1, 16'h0000);
    check("resume_inr", reg_out, 16'h0006);

    // ld+inr from all-ones must not raise the wrap flag.
    apply(0, 0, 1, 0, 16'hFFFF);
    apply(0, 0, 1, 1, 16'hFFFF);
    check("ld_inr_ones_wrap", reg_wrap, 1'b0);

`ifdef BC_REG_SHIFT_EN
    apply(0, 0, 1, 0, 16'h8001);
    reg_shl = 1; reg_sin = 0;
    apply(0, 0, 0, 0, 16'h0000);
    check("shl_out", reg_out, 16'h0002);
    check("shl_sout", reg_sout, 1'b1);
    reg_shl = 0; reg_shr = 1; reg_sin = 1;
    apply(0, 0, 0, 0, 16'h0000);
    check("shr_out", reg_out, 16'h8001);
    check("shr_sout", reg_sout, 1'b0);
    reg_shr = 0;
    apply(0, 0, 0, 0, 16'h0000);
    check("sout_hold", reg_sout, 1'b0);
`endif

    for (int k = 0; k < 3000; k++) begin
      logic [W-1:0] d;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      d = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'hFFFD : W'($urandom);
`ifdef BC_REG_SHIFT_EN
      reg_shl = ($urandom_range(0, 3) == 0);
      reg_shr = ($urandom_range(0, 3) == 0);
      reg_sin = 1'($urandom);
`endif
      apply(($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
